display_scan_driver: RTL and testbench

Sequential front end of the vending-machine display. It captures a 14-bit binary amount (credit or price) and converts it to four BCD digits with a shift-and-add-3 engine, one bit per clock. It then time-multiplexes those digits onto a single 7-bit digit bus that feeds the BCD-to-seven-segment decoder, and drives a one-hot digit-enable for the common-cathode display.

---
 rtl/display_pkg.sv | 44 ++++
 rtl/display_scan_driver_if.sv | 28 ++
 rtl/bin2bcd_seq.sv | 90 +++++++++
 rtl/display_scan_driver.sv | 92 +++++++++
 tb/tb_display_scan_driver.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/display_pkg.sv
// Shared definitions for the vending-machine display front end.
// Holds display geometry, the value clamp limit, the blank code understood
// by the seven-segment decoder, the converter state type and small helpers.
package display_pkg;

  localparam int DIGITS  = 4;
  localparam int BCD_W   = 4;
  localparam int VALUE_W = 14;

  localparam logic [VALUE_W-1:0] MAX_VALUE  = 14'd9999;
  localparam logic [6:0]         BLANK_CODE = 7'd127;

  // One shift per input bit.
  localparam logic [3:0] CONV_STEPS = 4'd14;

  typedef enum logic {
    IDLE = 1'b0,
    CONV = 1'b1
  } conv_state_t;

  // Amounts above the four-digit range display as all nines.
  function automatic logic [VALUE_W-1:0] clamp_value(input logic [VALUE_W-1:0] v);
    logic [VALUE_W-1:0] r;
    if (v > MAX_VALUE) begin
      r = MAX_VALUE;
    end else begin
      r = v;
    end
    return r;
  endfunction

  // Double-dabble correction: a nibble of 5 or more would overflow past 9
  // after the next doubling, so pre-add 3 to push the carry into the next digit.
  function automatic logic [BCD_W-1:0] add3_nibble(input logic [BCD_W-1:0] d);
    logic [BCD_W-1:0] r;
    if (d >= 4'd5) begin
      r = d + 4'd3;
    end else begin
      r = d;
    end
    return r;
  endfunction

endpackage

// File: rtl/display_scan_driver_if.sv
// Bundles the display front end's control and display signals.
//   value       : binary amount to show (captured on an accepted load)
//   load        : one-cycle capture request
//   blank_zeros : suppress leading zeros
//   number      : digit code to the seven-segment decoder (0..9 or blank)
//   digit_sel   : one-hot digit enable, bit 0 = least-significant digit
//   busy        : conversion in progress
// master = the controller driving the display, slave = display_scan_driver.
interface display_scan_driver_if;
  import display_pkg::*;

  logic [VALUE_W-1:0] value;
  logic               load;
  logic               blank_zeros;
  logic [6:0]         number;
  logic [DIGITS-1:0]  digit_sel;
  logic               busy;

  modport master (
    output value, load, blank_zeros,
    input  number, digit_sel, busy
  );

  modport slave (
    input  value, load, blank_zeros,
    output number, digit_sel, busy
  );
endinterface

// File: rtl/bin2bcd_seq.sv
// Iterative shift-and-add-3 (double-dabble) binary to BCD converter,
// one input bit per clock.
//   clk, rst : clock, asynchronous active-high reset
//   start    : begin a conversion of bin (ignored while busy)
//   bin      : binary input, clamped to the four-digit maximum on capture
//   busy     : conversion running
//   done     : high during the final shift cycle; bcd is valid that cycle
//   bcd      : four packed BCD digits produced by the final shift
module bin2bcd_seq
  import display_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [VALUE_W-1:0]       bin,
  output logic                     busy,
  output logic                     done,
  output logic [DIGITS*BCD_W-1:0]  bcd
);

  conv_state_t              state, state_next;
  logic [VALUE_W-1:0]       bin_sr, bin_sr_next;
  logic [DIGITS*BCD_W-1:0]  bcd_sr, bcd_sr_next, bcd_adj;
  logic [3:0]               iter, iter_next;
  logic [DIGITS*BCD_W+VALUE_W-1:0] work_shift;

  // Add-3 correction on every nibble, then one left shift of {bcd, bin}.
  always_comb begin
    bcd_adj = 16'd0;
    for (int k = 0; k < DIGITS; k++) begin
      bcd_adj[k*BCD_W +: BCD_W] = add3_nibble(bcd_sr[k*BCD_W +: BCD_W]);
    end
    work_shift = {bcd_adj, bin_sr} << 5'd1;
  end

  // Converter next-state and datapath control.
  always_comb begin
    state_next  = state;
    bin_sr_next = bin_sr;
    bcd_sr_next = bcd_sr;
    iter_next   = iter;
    done        = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next  = CONV;
          bin_sr_next = clamp_value(bin);
          bcd_sr_next = 16'd0;
          iter_next   = CONV_STEPS;
        end else begin
          state_next  = IDLE;
        end
      end
      CONV: begin
        bcd_sr_next = work_shift[DIGITS*BCD_W+VALUE_W-1 -: DIGITS*BCD_W];
        bin_sr_next = work_shift[VALUE_W-1:0];
        iter_next   = iter - 4'd1;
        if (iter == 4'd1) begin
          done       = 1'b1;
          state_next = IDLE;
        end else begin
          state_next = CONV;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Converter state and working registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      bin_sr <= 14'd0;
      bcd_sr <= 16'd0;
      iter   <= 4'd0;
    end else begin
      state  <= state_next;
      bin_sr <= bin_sr_next;
      bcd_sr <= bcd_sr_next;
      iter   <= iter_next;
    end
  end

  assign busy = (state == CONV);
  // Result of the final shift; the consumer latches it while done is high.
  assign bcd  = bcd_sr_next;

endmodule

// File: rtl/display_scan_driver.sv
// Display front end: converts a captured binary amount to four BCD digits
// and time-multiplexes them onto a single digit bus with a one-hot enable.
//   SCAN_DIV : clock cycles each digit stays enabled (>= 2)
//   clk, rst : clock, asynchronous active-high reset
//   bus      : slave side of display_scan_driver_if (value/load/blank_zeros
//              in, number/digit_sel/busy out)
module display_scan_driver
  import display_pkg::*;
#(
  parameter int SCAN_DIV = 50000
)
(
  input logic                   clk,
  input logic                   rst,
  display_scan_driver_if.slave  bus
);

  localparam int               CNT_W    = $clog2(SCAN_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

  logic                           conv_busy;
  logic                           conv_done;
  logic [DIGITS*BCD_W-1:0]        conv_bcd;
  logic [DIGITS-1:0][BCD_W-1:0]   digits;
  logic [CNT_W-1:0]               scan_cnt;
  logic [1:0]                     idx, idx_next;
  logic [6:0]                     number_next;
  logic                           lead_zero;
  logic [6:0]                     out_number;
  logic [DIGITS-1:0]              out_sel;

  bin2bcd_seq u_conv (
    .clk   (clk),
    .rst   (rst),
    .start (bus.load),
    .bin   (bus.value),
    .busy  (conv_busy),
    .done  (conv_done),
    .bcd   (conv_bcd)
  );

  // Displayed digits change only on the converter's final edge, so a
  // half-converted value is never visible.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digits <= 16'd0;
    end else if (conv_done) begin
      digits <= conv_bcd;
    end else begin
      digits <= digits;
    end
  end

  // Code to show in the upcoming slot, including leading-zero blanking.
  always_comb begin
    idx_next    = idx + 2'd1;
    lead_zero   = 1'b1;
    number_next = {3'd0, digits[idx_next]};
    // Blank when this digit and every more-significant digit is zero.
    for (int k = 0; k < DIGITS; k++) begin
      lead_zero = lead_zero & ((k < int'(idx_next)) | (digits[k] == 4'd0));
    end
    if (bus.blank_zeros && (idx_next != 2'd0) && lead_zero) begin
      number_next = BLANK_CODE;
    end else begin
      number_next = {3'd0, digits[idx_next]};
    end
  end

  // Scan counter, digit index and registered display outputs; the outputs
  // move together only on the wrap edge so each digit holds a full slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_cnt   <= '0;
      idx        <= 2'd0;
      out_number <= 7'd0;
      out_sel    <= 4'b0001;
    end else if (scan_cnt == CNT_LAST) begin
      scan_cnt   <= '0;
      idx        <= idx_next;
      out_number <= number_next;
      out_sel    <= 4'b0001 << idx_next;
    end else begin
      scan_cnt   <= scan_cnt + CNT_W'(1);
    end
  end

  assign bus.number    = out_number;
  assign bus.digit_sel = out_sel;
  assign bus.busy      = conv_busy;

endmodule

// File: tb/tb_display_scan_driver.sv
// Self-checking bench for display_scan_driver with SCAN_DIV = 4.
// A behavioural model (integer display value, edge count, decimal digit
// arithmetic) is stepped once per cycle and compared against the outputs
// at every falling edge; directed scenarios add literal frame checks.
module tb_display_scan_driver;

  localparam int SD = 4;

  logic clk;
  logic rst;

  display_scan_driver_if bus();

  display_scan_driver #(.SCAN_DIV(SD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  // Model state
  int   m_n;      // edges since reset release
  int   m_disp;   // value currently held by the digit registers
  int   m_idx;    // digit slot being shown
  int   m_num;    // expected number output
  int   m_left;   // edges until commit
  int   m_val;    // clamped value in flight
  bit   m_busy;

  // Inputs as they stand during the coming rising edge
  logic        s_load;
  logic [13:0] s_value;
  logic        s_blank;

  function automatic int pow10(input int k);
    int p;
    p = 1;
    for (int i = 0; i < k; i++) p = p * 10;
    return p;
  endfunction

  // Decimal digit k of v, or blank when v has fewer than k+1 digits.
  function automatic int slot_code(input int v, input int k, input logic blank);
    if (blank && k > 0 && v < pow10(k)) return 127;
    return (v / pow10(k)) % 10;
  endfunction

  task automatic cmp(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // One clock: advance the model over the rising edge, then compare.
  task automatic step();
    s_load  = bus.load;
    s_value = bus.value;
    s_blank = bus.blank_zeros;
    @(negedge clk);
    if (rst) begin
      m_n = 0; m_disp = 0; m_idx = 0; m_num = 0;
      m_busy = 1'b0; m_left = 0; m_val = 0;
    end else begin
      m_n++;
      if (m_n % SD == 0) begin
        m_idx = (m_idx + 1) % 4;
        m_num = slot_code(m_disp, m_idx, s_blank);
      end
      if (m_busy) begin
        m_left--;
        if (m_left == 0) begin
          m_busy = 1'b0;
          m_disp = m_val;
        end
      end else if (s_load) begin
        m_busy = 1'b1;
        m_left = 14;
        m_val  = (s_value > 14'd9999) ? 9999 : int'(s_value);
      end
    end
    cmp("number",    int'(bus.number),    m_num);
    cmp("digit_sel", int'(bus.digit_sel), 1 << m_idx);
    cmp("busy",      int'(bus.busy),      int'(m_busy));
  endtask

  task automatic pulse_load(input int v);
    bus.value = 14'(v);
    bus.load  = 1'b1;
    step();
    bus.load  = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int i;
    i = 0;
    while (bus.busy && i < 40) begin
      step();
      i++;
    end
    cmp({name, "_idle"}, int'(bus.busy), 0);
  endtask

  // Find the next slot-0 start and check the four digits of that frame.
  task automatic check_frame(input string name, input int e0, input int e1,
                             input int e2, input int e3);
    int exp[4];
    logic [3:0] prev;
    bit found;
    exp[0] = e0; exp[1] = e1; exp[2] = e2; exp[3] = e3;
    found = 1'b0;
    prev  = bus.digit_sel;
    for (int i = 0; i < 24 && !found; i++) begin
      step();
      if (bus.digit_sel == 4'b0001 && prev != 4'b0001) found = 1'b1;
      prev = bus.digit_sel;
    end
    cmp({name, "_frame_start"}, int'(found), 1);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) repeat (SD) step();
      cmp($sformatf("%s_d%0d", name, k),   int'(bus.number),    exp[k]);
      cmp($sformatf("%s_sel%0d", name, k), int'(bus.digit_sel), 1 << k);
    end
  endtask

  initial begin
    int cnt;
    rst             = 1'b1;
    bus.load        = 1'b0;
    bus.value       = 14'd0;
    bus.blank_zeros = 1'b0;
    repeat (3) step();
    cmp("reset_sel",    int'(bus.digit_sel), 1);
    cmp("reset_number", int'(bus.number),    0);
    cmp("reset_busy",   int'(bus.busy),      0);
    rst = 1'b0;

    // Reset mid-scan, then watch the index walk every SCAN_DIV cycles
    repeat (10) step();
    rst = 1'b1;
    step();
    cmp("midscan_reset_sel", int'(bus.digit_sel), 1);
    rst = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      step();
      case (i)
        1:       cmp("walk_e1",  int'(bus.digit_sel), 4'b0001);
        4:       cmp("walk_e4",  int'(bus.digit_sel), 4'b0010);
        8:       cmp("walk_e8",  int'(bus.digit_sel), 4'b0100);
        12:      cmp("walk_e12", int'(bus.digit_sel), 4'b1000);
        16:      cmp("walk_e16", int'(bus.digit_sel), 4'b0001);
        default: ;
      endcase
    end

    // 1234 without blanking; busy spans exactly 14 cycles
    bus.blank_zeros = 1'b0;
    pulse_load(1234);
    cnt = bus.busy ? 1 : 0;
    for (int i = 0; i < 40 && bus.busy; i++) begin
      step();
      if (bus.busy) cnt++;
    end
    cmp("busy_cycles", cnt, 14);
    check_frame("v1234", 4, 3, 2, 1);

    // Clamp
    pulse_load(12000);
    wait_idle("v12000");
    check_frame("v12000", 9, 9, 9, 9);

    // Leading-zero blanking
    bus.blank_zeros = 1'b1;
    pulse_load(7);
    wait_idle("v7");
    check_frame("v7", 7, 127, 127, 127);
    pulse_load(0);
    wait_idle("v0");
    check_frame("v0", 0, 127, 127, 127);
    pulse_load(1005);
    wait_idle("v1005");
    check_frame("v1005", 5, 0, 0, 1);

    // Load during a conversion is dropped; afterwards it is accepted
    pulse_load(1234);
    repeat (4) step();
    pulse_load(42);
    wait_idle("ignore42");
    check_frame("ignore42", 4, 3, 2, 1);
    pulse_load(42);
    wait_idle("accept42");
    check_frame("accept42", 2, 4, 127, 127);

    // Reset in the middle of a conversion: no commit afterwards
    bus.blank_zeros = 1'b0;
    pulse_load(5678);
    repeat (6) step();
    rst = 1'b1;
    step();
    cmp("abort_sel",    int'(bus.digit_sel), 1);
    cmp("abort_number", int'(bus.number),    0);
    cmp("abort_busy",   int'(bus.busy),      0);
    rst = 1'b0;
    repeat (30) step();
    check_frame("after_abort", 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
